// File: rtl/word_compare_pkg.sv
// ----------------------------------------------------------------------------
// word_compare_pkg
// Shared encodings for the sequential word comparator (word_compare_seq).
//   state_t    : controller states IDLE -> RUN -> DONE -> IDLE
//   verdict_t  : comparison verdict EQ / LT / GT
//   idx_width(): width of the slice index counter (clog2 of slice count, min 1)
// No ports; imported by word_compare_seq and cmp2_slice.
// ----------------------------------------------------------------------------
package word_compare_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        V_EQ = 2'd0,
        V_LT = 2'd1,
        V_GT = 2'd2
    } verdict_t;

    // A single slice still needs a 1-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/word_compare_seq_cmp2_slice.sv
// ----------------------------------------------------------------------------
// cmp2_slice
// Purely combinational unsigned compare of two 2-bit slices.
// Ports:
//   a   in  2  slice of operand A
//   b   in  2  slice of operand B
//   eq  out 1  a == b
//   lt  out 1  a <  b
//   gt  out 1  a >  b
// Exactly one of eq/lt/gt is high for any input.
// ----------------------------------------------------------------------------
module cmp2_slice
    import word_compare_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       lt,
    output logic       gt
);

    // MSB decides unless the MSBs match, then the LSB decides.
    always_comb begin
        eq = 1'b0;
        lt = 1'b0;
        gt = 1'b0;
        if (a[1] != b[1]) begin
            lt = b[1];
            gt = a[1];
        end else if (a[0] != b[0]) begin
            lt = b[0];
            gt = a[0];
        end else begin
            eq = 1'b1;
        end
    end

endmodule

// File: rtl/word_compare_seq.sv
// ----------------------------------------------------------------------------
// word_compare_seq
// Sequential magnitude comparator for WIDTH-bit unsigned words. A single
// 2-bit compare slice is time-multiplexed over the operand pairs, most
// significant pair first. A start/done handshake frames each operation and
// the result flags hold until the next operation completes (or reset).
//
// Handshake: start is sampled only in a cycle where ready=1 (IDLE). The
// operands are captured on that edge; start or operand changes afterwards
// are ignored (not queued) until ready returns. done is a one-cycle pulse
// in the DONE state and the result flags are valid from that cycle on.
//
// Parameters:
//   WIDTH  operand width, even and >= 2 (NSLICE = WIDTH/2 slices)
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   start   in   1      request, honoured only while ready=1
//   a       in   WIDTH  operand A, captured with start
//   b       in   WIDTH  operand B, captured with start
//   ready   out  1      high in IDLE
//   busy    out  1      high in RUN
//   done    out  1      one-cycle completion pulse
//   a_eq_b  out  1      registered result A == B
//   a_lt_b  out  1      registered result A <  B
//   a_gt_b  out  1      registered result A >  B
//
// Build option: define WCS_EARLY_EXIT_EN to leave RUN on the first differing
// slice. Without it every operation takes NSLICE RUN cycles and the sticky
// verdict keeps the first difference. Results are identical either way.
// ----------------------------------------------------------------------------
module word_compare_seq
    import word_compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gt_b
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDX_W-1:0] idx;
    logic             decided;
    verdict_t         verdict_r;

    // ------------------------------------------------------------------
    // Slice mux and compare
    // ------------------------------------------------------------------
    logic [1:0] a_sl;
    logic [1:0] b_sl;
    logic       sl_eq;
    logic       sl_lt;
    logic       sl_gt;
    verdict_t   slice_verdict;
    verdict_t   verdict_nxt;
    logic       last_slice;
    logic       run_exit;

    // {idx, 1'b0} is 2*idx, the LSB position of the current pair.
    assign a_sl = a_r[{idx, 1'b0} +: 2];
    assign b_sl = b_r[{idx, 1'b0} +: 2];

    cmp2_slice u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .eq (sl_eq),
        .lt (sl_lt),
        .gt (sl_gt)
    );

    always_comb begin
        slice_verdict = V_EQ;
        if (sl_lt) begin
            slice_verdict = V_LT;
        end else if (sl_gt) begin
            slice_verdict = V_GT;
        end
    end

    // A verdict fixed by a more significant slice always wins.
    assign verdict_nxt = decided ? verdict_r : slice_verdict;
    assign last_slice  = (idx == '0);

`ifdef WCS_EARLY_EXIT_EN
    assign run_exit = last_slice || !sl_eq;
`else
    assign run_exit = last_slice;
`endif

    // ------------------------------------------------------------------
    // FSM next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (run_exit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, index counter, sticky verdict, results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            idx       <= '0;
            decided   <= 1'b0;
            verdict_r <= V_EQ;
            a_eq_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_gt_b    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        idx       <= IDX_LAST;
                        decided   <= 1'b0;
                        verdict_r <= V_EQ;
                    end
                end
                S_RUN: begin
                    if (!decided && !sl_eq) begin
                        decided   <= 1'b1;
                        verdict_r <= slice_verdict;
                    end
                    if (run_exit) begin
                        // Results change only on the edge entering DONE.
                        a_eq_b <= (verdict_nxt == V_EQ);
                        a_lt_b <= (verdict_nxt == V_LT);
                        a_gt_b <= (verdict_nxt == V_GT);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
